// File: rtl/exec_hazard_ctrl_pkg.sv
// Shared types and encodings for the decode/execute hazard controller.
// Stage tags describe the destination of whatever sits in EX and MEM.
package exec_hazard_ctrl_pkg;

   localparam int TAG_DST_W = 3;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [3:0] ALU_NOP = 4'b1111;

   typedef struct packed {
      logic                 valid;
      logic                 writes;
      logic                 isLoad;
      logic [TAG_DST_W-1:0] dst;
   } stage_tag_t;

   typedef enum logic {IDLE, STALL} hz_state_t;

   // True when the staged instruction will write register a.
   function automatic logic tagMatch(input stage_tag_t t, input logic [TAG_DST_W-1:0] a);
      return t.valid & t.writes & (t.dst == a);
   endfunction

endpackage

// File: rtl/exec_hazard_ctrl_fwd_select.sv
// Forwarding select for one operand: youngest in-flight writer wins,
// an unused operand always reads the register file.
module fwd_select
   import exec_hazard_ctrl_pkg::*;
#(
   parameter int ADDR_W = TAG_DST_W
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              used,
   input  logic              exValid,
   input  logic              exWrites,
   input  logic [ADDR_W-1:0] exDst,
   input  logic              memValid,
   input  logic              memWrites,
   input  logic [ADDR_W-1:0] memDst,
   output logic [1:0]        sel
);

   logic exHit;
   logic memHit;

   assign exHit  = exValid & exWrites & (exDst == addr);
   assign memHit = memValid & memWrites & (memDst == addr);

   always_comb begin
      sel = FWD_REG;
      if (used) begin
         if (exHit)       sel = FWD_EX;
         else if (memHit) sel = FWD_MEM;
      end
   end

endmodule

// File: rtl/exec_hazard_ctrl.sv
// Issue/hazard controller between decode and execute: shadow EX/MEM tags,
// registered forwarding selects, and load-use stall with bubble insertion.
module exec_hazard_ctrl
   import exec_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = TAG_DST_W,
   parameter int LU_STALL   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hold,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_src,
   input  logic [REG_ADDR_W-1:0] id_dst,
   input  logic                  id_uses_src,
   input  logic                  id_uses_dst,
   input  logic                  id_writes,
   input  logic                  id_is_load,
   input  logic [3:0]            id_alu_ctrl,
   output logic                  if_id_stall,
   output logic                  ex_valid,
   output logic [1:0]            ex_select_src,
   output logic [1:0]            ex_select_dst,
   output logic                  ex_imm_or_reg,
   output logic [3:0]            ex_alu_ctrl,
   output logic                  ex_flag_en
);

   localparam int              CNT_W    = 2;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LU_STALL - 1);

   stage_tag_t       exTag;
   stage_tag_t       memTag;
   stage_tag_t       issueTag;
   hz_state_t        state;
   hz_state_t        stateNext;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cntNext;
   logic             hazardDetect;
   logic             hazardStall;
   logic             issue;
   logic [1:0]       fwdSrc;
   logic [1:0]       fwdDst;

   fwd_select #(.ADDR_W(REG_ADDR_W)) uFwdSrc (
      .addr      (id_src),
      .used      (id_uses_src),
      .exValid   (exTag.valid),
      .exWrites  (exTag.writes),
      .exDst     (exTag.dst),
      .memValid  (memTag.valid),
      .memWrites (memTag.writes),
      .memDst    (memTag.dst),
      .sel       (fwdSrc)
   );

   fwd_select #(.ADDR_W(REG_ADDR_W)) uFwdDst (
      .addr      (id_dst),
      .used      (id_uses_dst),
      .exValid   (exTag.valid),
      .exWrites  (exTag.writes),
      .exDst     (exTag.dst),
      .memValid  (memTag.valid),
      .memWrites (memTag.writes),
      .memDst    (memTag.dst),
      .sel       (fwdDst)
   );

   // A load in EX cannot forward yet; only its consumers in ID must wait.
   assign hazardDetect = id_valid & exTag.isLoad &
                         ((id_uses_src & tagMatch(exTag, id_src)) |
                          (id_uses_dst & tagMatch(exTag, id_dst)));

   assign issueTag = '{valid: 1'b1, writes: id_writes, isLoad: id_is_load, dst: id_dst};

   always_comb begin
      stateNext   = state;
      cntNext     = cnt;
      hazardStall = 1'b0;
      if (flush) begin
         stateNext = IDLE;
         cntNext   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (hazardDetect) begin
                  hazardStall = 1'b1;
                  cntNext     = CNT_LOAD;
                  stateNext   = (LU_STALL > 1) ? STALL : IDLE;
               end
            end
            STALL: begin
               // cnt==0 is the release cycle: the held instruction issues now.
               if (cnt == '0) begin
                  stateNext = IDLE;
               end else begin
                  hazardStall = 1'b1;
                  cntNext     = cnt - 1'b1;
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   assign if_id_stall = hold | hazardStall;
   assign issue       = id_valid & ~flush & ~hazardStall;
   assign ex_flag_en  = ex_valid & (ex_alu_ctrl != ALU_NOP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (!hold) begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exTag         <= '0;
         memTag        <= '0;
         ex_valid      <= 1'b0;
         ex_select_src <= FWD_REG;
         ex_select_dst <= FWD_REG;
         ex_imm_or_reg <= 1'b0;
         ex_alu_ctrl   <= ALU_NOP;
      end else if (!hold) begin
         memTag        <= exTag;
         exTag         <= issue ? issueTag : '0;
         ex_valid      <= issue;
         ex_select_src <= issue ? fwdSrc : FWD_REG;
         ex_select_dst <= issue ? fwdDst : FWD_REG;
         ex_imm_or_reg <= issue & id_uses_dst;
         ex_alu_ctrl   <= issue ? id_alu_ctrl : ALU_NOP;
      end
   end

endmodule

// File: doc/exec_hazard_ctrl.md
Name: exec_hazard_ctrl

Overview:
- Issue/hazard controller sitting between decode and the execute stage.
- Tracks destination tags of the instructions in EX and MEM in a shadow pipeline.
- Produces registered forwarding selects (selectSrc/selectDst encoding) and the ALU control for the execute stage.
- Detects load-use hazards and stalls decode for a programmable number of cycles, inserting bubbles (ALU op 4'b1111 "do nothing") into EX.

Parameters:
- REG_ADDR_W, 3, register-file address width (8 GPRs, all writable, no hardwired zero).
- LU_STALL, 1, bubbles inserted on a load-use hazard; legal range 1..3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- hold  in  1  global freeze (memory wait); all state holds.
- flush  in  1  taken branch/jump; kills the instruction in ID.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  REG_ADDR_W  source register (Rsrc).
- id_dst  in  REG_ADDR_W  Rdst, read as operand 2 and/or written.
- id_uses_src  in  1  Rsrc is read.
- id_uses_dst  in  1  Rdst is read as operand 2 (ImmOrReg=1).
- id_writes  in  1  instruction writes Rdst.
- id_is_load  in  1  write data comes from memory.
- id_alu_ctrl  in  4  ALU opcode from decode.
- if_id_stall  out  1  freeze PC and IF/ID latch.
- ex_valid  out  1  EX holds a real instruction.
- ex_select_src  out  2  00 reg file, 01 EX/MEM latch, 10 MEM/WB latch.
- ex_select_dst  out  2  same encoding; 00 whenever the immediate is used.
- ex_imm_or_reg  out  1  registered id_uses_dst.
- ex_alu_ctrl  out  4  ALU opcode in EX; 4'b1111 on a bubble.
- ex_flag_en  out  1  ex_valid and ex_alu_ctrl != 4'b1111; enables the CCR write.

Behaviour:
- Reset (async, immediate):
  - ex/mem tags invalid; FSM in IDLE; counter 0.
  - Outputs: if_id_stall 0, ex_valid 0, selects 00, ex_imm_or_reg 0, ex_alu_ctrl 4'b1111, ex_flag_en 0.
- Tag = {valid, writes, is_load, dst}. Tags advance on every clk edge with hold=0: mem_tag <= ex_tag; ex_tag <= issue ? ID fields : invalid.
- issue = id_valid & ~flush & ~hazard_stall.
- Forwarding selects are computed from ID fields against the current tags and registered at issue, so they align with the instruction in EX next cycle:
  - src: 01 if ex_tag valid&writes&dst==id_src.
  - else 10 if mem_tag valid&writes&dst==id_src.
  - else 00. EX match has priority over MEM.
  - dst: same rule with id_dst, gated by id_uses_dst; otherwise 00.
  - Operand unused -> 00.
- Load-use detect (combinational): ex_tag valid&is_load&writes, and its dst matches a used ID source.
- FSM:
  - IDLE: on detect with hold=0 and flush=0: if_id_stall=1, bubble into EX, cnt<=LU_STALL-1. Go to STALL if LU_STALL>1; otherwise stay IDLE, and the next cycle re-evaluates.
  - STALL: if_id_stall=1, bubble each cycle, cnt decrements. When cnt==0, return to IDLE and issue that cycle.
- Selects after a stall come from the recomputed tags:
  - LU_STALL=1: load is in MEM -> 10.
  - LU_STALL>=2: load has retired -> 00. The register file is write-before-read.
- Priority: rst > hold > flush > hazard stall.
  - hold: freezes tags, FSM, counter and all outputs; if_id_stall is driven 1.
  - flush: bubble into EX, FSM to IDLE, cnt cleared, if_id_stall 0. Applies mid-stall as well.
- A bubble registers ex_valid 0, ex_alu_ctrl 4'b1111, selects 00. The ALU holds its result and ex_flag_en=0 leaves the CCR untouched.
- A non-load producer never stalls. Back-to-back dependent instructions forward 01 with zero penalty.

Decomposition:
- Shared package holds:
  - FWD_REG=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10.
  - ALU_NOP=4'b1111.
  - the stage_tag_t struct {valid, writes, is_load, dst}.
  - the FSM state enum {IDLE, STALL}.
- One sub-module, fwd_select, is the natural split: pure combinational compare of one operand address against ex/mem tags returning the 2-bit select. It is instantiated twice.

Test Plan:
- ADD R1 then ADD R2,R1 back-to-back -> second instruction in EX has ex_select_src=01, no stall.
- ADD R3, NOP, then SUB using R3 as Rdst operand -> ex_select_dst=10.
- LDD R4, then ADD using R4, with LU_STALL=1:
  - one cycle of if_id_stall=1.
  - bubble in EX with ex_alu_ctrl=1111 and ex_flag_en=0.
  - ADD then enters EX with select 10.
- Same sequence with LU_STALL=3 -> three stall cycles, then ADD issues with select 00.
- LDD R5 / dependent instruction, with flush asserted during the stall -> stall drops that cycle, EX receives a bubble, FSM back to IDLE.
- hold asserted for 2 cycles mid-stall -> tags and counter frozen, total stall extends by exactly 2 cycles.
- rst asserted mid-stall -> all outputs return to reset values asynchronously.
